// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial sequencer driving an external combinational 1-bit ALU.
// Operand bits are presented LSB-first with a rippling carry. The ALU's y bits are
// shifted into a result register, and the completed word is published together
// with carry and zero flags.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_sel,
  input  logic             alu_y,
  input  logic             alu_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_zero;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_shift;

  logic             w_run;
  logic             w_accept;
  logic             w_arith;
  logic             w_last;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_run       = (r_state == S_RUN);
  // A new request is taken whenever no serial operation is in flight (IDLE or DONE).
  assign w_accept    = start && (r_state != S_RUN);
  // Only ADD and SUB use the carry chain; every other opcode sees cin=0.
  assign w_arith     = (r_op[2:1] == 2'b00);
  assign w_last      = (r_cnt == LAST_IDX);
  assign w_shift_nxt = {alu_y, r_shift[WIDTH-1:1]};

  // The ALU side is driven only while running, and is quiet in IDLE/DONE.
  assign alu_a   = w_run & r_opa[r_cnt];
  assign alu_b   = w_run & r_opb[r_cnt];
  assign alu_cin = w_run & w_arith & r_carry;
  assign alu_sel = w_run ? r_op : 3'b000;

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign zero      = r_zero;

  // Control FSM: sequences IDLE -> RUN (WIDTH cycles) -> DONE and publishes the flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            // SUB is computed as a + ~b + 1, so the chain is seeded with 1.
            r_carry <= (op == 3'b001);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_cnt   <= r_cnt + 1'b1;
          r_carry <= alu_cout;
          if (w_last) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_result    <= w_shift_nxt;
            r_carry_out <= w_arith & alu_cout;
            r_zero      <= (w_shift_nxt == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand capture on acceptance, plus the internal LSB-first result shifter.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_opa   <= opa;
      r_opb   <= opb;
      r_op    <= op;
      r_shift <= '0;
    end else if (w_run) begin
      r_shift <= w_shift_nxt;
    end
  end

endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
- Bit-serial sequencer that drives the team's 1-bit ALU from the operand side.
- Accepts a WIDTH-bit operation request, presents operand bits to the ALU LSB-first with a rippling carry, and collects the ALU's y/cout outputs. It then assembles a WIDTH-bit result with carry and zero flags.
- Sits between a host/testbench command interface and one combinational 1-bit ALU instance.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; accepted only when busy=0
op  input  3  ALU opcode: 000 ADD, 001 SUB, 010 MUL(1-bit AND), 011 NOT a, 100 AND, 101 OR, 110 XOR, 111 XNOR
opa  input  WIDTH  operand A, sampled with start
opb  input  WIDTH  operand B, sampled with start
busy  output  1  high while a serial operation is in progress
done  output  1  one-cycle pulse when result/flags are valid
result  output  WIDTH  assembled result, held until next accepted start
carry_out  output  1  final ALU cout for ADD/SUB; 0 for other ops
zero  output  1  result == 0, valid with done, held
alu_a  output  1  operand A bit to ALU
alu_b  output  1  operand B bit to ALU
alu_cin  output  1  carry-in bit to ALU
alu_sel  output  3  opcode to ALU
alu_y  input  1  ALU result bit (combinational from alu_a/b/cin/sel)
alu_cout  input  1  ALU carry-out bit

Behaviour:
- Clock/reset: one clock, clk; rst synchronous active-high.
- Reset values: busy=0, done=0, result=0, carry_out=0, zero=0, alu_a=0, alu_b=0, alu_cin=0, alu_sel=000. State is IDLE, bit counter is 0, carry register is 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - ALU-side outputs are driven 0.
  - start=1 at an edge latches opa, opb and op into internal registers and clears the result shift register.
  - The carry register loads 1 if op=001, otherwise 0.
  - Counter goes to 0. Next state is RUN; busy=1 from that edge.
- RUN, per cycle with idx = counter:
  - alu_a=opa_r[idx], alu_b=opb_r[idx], alu_sel=op_r.
  - alu_cin = carry register for op 000/001; 0 for all other ops.
  - At each edge: alu_y shifts into result MSB (shift right); the carry register loads alu_cout; counter increments.
  - When idx=WIDTH-1 at the edge, next state is DONE.
- SUB: the ALU computes a+~b+cin. The initial cin=1 gives two's-complement a-b. carry_out=1 means no borrow (opa>=opb unsigned).
- DONE (exactly one cycle):
  - done=1, busy=0.
  - result holds the assembled value, LSB-aligned.
  - carry_out = carry register for op 000/001, else 0.
  - zero = (result==0).
  - Next state is IDLE.
- Latency: start accepted at edge k; busy high after edges k..k+WIDTH-1; done high for the single cycle after edge k+WIDTH.
- Start acceptance:
  - start is accepted in IDLE and in DONE (busy=0). Accepting in DONE gives back-to-back operations; done still pulses that cycle and the next state is RUN.
  - start while busy=1 is ignored. Operand registers and op_r are unaffected.
- Output hold: result/carry_out/zero update only in DONE. During RUN the result register shifts internally but the result port keeps the previous completed value (separate output register).
- Reset mid-operation: at the rst edge all outputs and state return to reset values; no done pulse; the partial result is discarded.
- opa/opb/op changes after acceptance have no effect.
- Unused ALU carry for logic ops is ignored; the carry register still loads but carry_out reports 0.

Test Plan:
- Reset with random inputs -> all outputs 0, busy=0; start with rst=1 is ignored.
- ADD opa=0x5A opb=0x3C -> done exactly 8 cycles after the start edge, result=0x96, carry_out=0, zero=0. ADD 0xFF+0x01 -> result=0x00, carry_out=1, zero=1.
- SUB 0x10-0x01 -> result=0x0F, carry_out=1. SUB 0x01-0x02 -> result=0xFF, carry_out=0. Check alu_cin=1 on the first RUN cycle only from init; later cycles follow alu_cout.
- Logic ops, opa=0xF0 opb=0xAA:
  - XOR -> 0x5A; XNOR -> 0xA5; OR -> 0xFA; AND -> 0xA0.
  - MUL -> 0xA0; NOT -> 0x0F.
  - carry_out=0 for all six.
- Handshake: start re-asserted mid-RUN with different operands -> ignored, original result returned. start held in the DONE cycle -> second operation begins, busy=1 next cycle, both results correct.
- Reset asserted on the 3rd RUN cycle -> busy=0, done never pulses, result=0. A subsequent ADD 0x01+0x01 -> 0x02.
